// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_pkg
//   Shared definitions for the countdown timer block: FSM state encoding,
//   the default counter width and the prescaler width helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Width of the prescaler counter: max(1, clog2(prescale)).
    function automatic int prescale_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
//   Valid/ready load port of the countdown timer.
//   load_valid : load request, load_val valid while high
//   load_ready : load accepted when load_valid & load_ready at posedge
//   load_val   : value written into the count and reload registers
//   master modport drives the request, slave modport (the timer) accepts it.
// ---------------------------------------------------------------------------
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_val;

    modport master (
        output load_valid,
        output load_val,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_val,
        output load_ready
    );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// ---------------------------------------------------------------------------
// countdown_timer_tick_gen
//   Prescaler for the countdown timer. Counts 0..PRESCALE-1 while enabled and
//   raises tick in the cycle the counter sits at PRESCALE-1. When disabled the
//   phase is frozen; clear returns it to 0.
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   enable : advance the prescaler this cycle
//   clear  : force the prescaler back to phase 0
//   tick   : decrement strobe (combinational)
// ---------------------------------------------------------------------------
module countdown_timer_tick_gen
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick = enable && (presc_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns presc_d and no latch is inferred.
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking for state so every flop samples pre-edge values.
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   Loads a WIDTH-bit value over a valid/ready port and counts it down to
//   zero, one step every PRESCALE clocks. Emits a one-cycle expire pulse and a
//   sticky irq at expiry; either reloads and keeps running (auto_reload) or
//   stops in IDLE (one-shot).
//   clk         : clock
//   reset       : asynchronous, active-high reset
//   load_if     : load port (slave side), accepted whenever not running
//   start       : level, enter RUN from IDLE/HOLD if the count is nonzero
//   stop        : level, RUN -> HOLD with count and prescaler frozen
//   auto_reload : sampled at expiry, 1 = reload and keep running
//   irq_ack     : clears irq
//   cnt         : current count (registered)
//   running     : state == RUN
//   expire      : registered one-cycle pulse after the final decrement
//   irq         : sticky expiry flag
// ---------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave load_if,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] cnt,
    output logic             running,
    output logic             expire,
    output logic             irq
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             expire_q;
    logic             expire_d;
    logic             irq_q;
    logic             irq_d;

    logic             load_ready;
    logic             load_fire;
    logic             tick_en;
    logic             tick;

    // Loads are refused only while counting, so a running count can never be
    // replaced mid-flight.
    assign load_ready         = (state_q != ST_RUN);
    assign load_if.load_ready = load_ready;
    assign load_fire          = load_if.load_valid && load_ready;

    // stop freezes the prescaler in the same cycle, which is what gives stop
    // priority over a coincident tick.
    assign tick_en = (state_q == ST_RUN) && !stop;

    countdown_timer_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (load_fire),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (load_fire) begin
            cnt_d    = load_if.load_val;
            reload_d = load_if.load_val;
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                // Decide on the post-load count so load+start runs the new value.
                // stop dominates start in every state.
                if (start && !stop && (cnt_d != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (tick && (cnt_q != '0)) begin
                    if (cnt_q == ONE) begin
                        expire_d = 1'b1;
                        if (auto_reload) begin
                            // Jump straight to the reload value: 0 is never shown.
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set wins over a same-cycle acknowledge.
        irq_d = expire_d || (irq_q && !irq_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    assign cnt     = cnt_q;
    assign running = (state_q == ST_RUN);
    assign expire  = expire_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Self-checking bench for countdown_timer. Two instances share clk/reset:
//   dut_a with PRESCALE=1 and dut_b with PRESCALE=3. Expected per-cycle
//   {cnt, expire, running} triples come from a small reference model and are
//   queued when a run is started, then popped one per clock.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         expire;
        logic         running;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic         a_start = 1'b0, a_stop = 1'b0, a_ar = 1'b0, a_ack = 1'b0;
    logic [W-1:0] a_cnt;
    logic         a_running, a_expire, a_irq;

    logic         b_start = 1'b0, b_stop = 1'b0, b_ar = 1'b0, b_ack = 1'b0;
    logic [W-1:0] b_cnt;
    logic         b_running, b_expire, b_irq;

    countdown_timer_if #(.WIDTH(W)) if_a ();
    countdown_timer_if #(.WIDTH(W)) if_b ();

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .load_if     (if_a),
        .start       (a_start),
        .stop        (a_stop),
        .auto_reload (a_ar),
        .irq_ack     (a_ack),
        .cnt         (a_cnt),
        .running     (a_running),
        .expire      (a_expire),
        .irq         (a_irq)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .load_if     (if_b),
        .start       (b_start),
        .stop        (b_stop),
        .auto_reload (b_ar),
        .irq_ack     (b_ack),
        .cnt         (b_cnt),
        .running     (b_running),
        .expire      (b_expire),
        .irq         (b_irq)
    );

    obs_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected outputs for cycles c = 0..ncyc-1 after the
    // edge that started a run of n counts at prescale p.
    task automatic push_run(input int n, input int p, input bit auto_r, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            obs_t e;
            int   dec;
            dec = c / p;
            if (auto_r) begin
                e.cnt     = W'(n - (dec % n));
                e.expire  = (c > 0) && ((c % (n * p)) == 0);
                e.running = 1'b1;
            end else begin
                if (dec > n) dec = n;
                e.cnt     = W'(n - dec);
                e.expire  = (c == n * p);
                e.running = (dec < n);
            end
            sb_q.push_back(e);
        end
    endtask

    function automatic obs_t observe(input bit sel);
        return sel ? {b_cnt, b_expire, b_running} : {a_cnt, a_expire, a_running};
    endfunction

    // Scoreboard consumer: pops one expectation per clock, first one now.
    task automatic drain(input bit sel, input string name);
        int c = 0;
        while (sb_q.size() > 0) begin
            obs_t e;
            obs_t o;
            e = sb_q.pop_front();
            o = observe(sel);
            total++;
            if (o !== e)
                $display("FAIL %s c%0d: got cnt=%0d expire=%b running=%b, want cnt=%0d expire=%b running=%b",
                         name, c, o.cnt, o.expire, o.running, e.cnt, e.expire, e.running);
            else
                passed++;
            if (sb_q.size() > 0) begin
                step();
                c++;
            end
        end
    endtask

    task automatic test_reset();
        if_a.load_valid = 1'b0; if_a.load_val = '0;
        if_b.load_valid = 1'b0; if_b.load_val = '0;
        reset = 1'b1;
        step();
        step();
        total++; if (a_cnt !== '0)           $display("FAIL reset_cnt: got %0d want 0", a_cnt);                else passed++;
        total++; if (a_irq !== 1'b0)         $display("FAIL reset_irq: got %b want 0", a_irq);                 else passed++;
        total++; if (a_expire !== 1'b0)      $display("FAIL reset_expire: got %b want 0", a_expire);           else passed++;
        total++; if (if_a.load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if_a.load_ready);   else passed++;
        total++; if (a_running !== 1'b0)     $display("FAIL reset_running: got %b want 0", a_running);         else passed++;
        total++; if (b_cnt !== '0)           $display("FAIL reset_b_cnt: got %0d want 0", b_cnt);              else passed++;
        total++; if (if_b.load_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", if_b.load_ready); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        if_a.load_val = W'(5); if_a.load_valid = 1'b1; a_start = 1'b1; a_ar = 1'b0;
        push_run(5, 1, 1'b0, 7);
        step();
        if_a.load_valid = 1'b0; a_start = 1'b0;
        drain(1'b0, "oneshot5");
        total++; if (a_irq !== 1'b1)           $display("FAIL oneshot_irq: got %b want 1", a_irq);             else passed++;
        total++; if (if_a.load_ready !== 1'b1) $display("FAIL oneshot_ready: got %b want 1", if_a.load_ready); else passed++;
    endtask

    task automatic test_auto_reload();
        if_b.load_val = W'(2); if_b.load_valid = 1'b1; b_start = 1'b1; b_ar = 1'b1;
        push_run(2, 3, 1'b1, 14);
        step();
        if_b.load_valid = 1'b0; b_start = 1'b0;
        drain(1'b1, "reload2");
        b_stop = 1'b1;
        step();
        b_stop = 1'b0; b_ar = 1'b0;
        total++; if (b_running !== 1'b0) $display("FAIL reload_stop_running: got %b want 0", b_running); else passed++;
        total++; if (b_cnt !== W'(2))    $display("FAIL reload_stop_cnt: got %0d want 2", b_cnt);        else passed++;
        total++; if (b_irq !== 1'b1)     $display("FAIL reload_irq: got %b want 1", b_irq);              else passed++;
    endtask

    task automatic test_stop_resume();
        if_a.load_val = W'(10); if_a.load_valid = 1'b1; a_start = 1'b1;
        push_run(10, 1, 1'b0, 4);
        step();
        if_a.load_valid = 1'b0; a_start = 1'b0;
        drain(1'b0, "pre_stop");
        a_stop = 1'b1;
        step();
        total++; if (a_cnt !== W'(7))          $display("FAIL stop_cnt: got %0d want 7", a_cnt);            else passed++;
        total++; if (a_running !== 1'b0)       $display("FAIL stop_running: got %b want 0", a_running);     else passed++;
        total++; if (if_a.load_ready !== 1'b1) $display("FAIL stop_ready: got %b want 1", if_a.load_ready); else passed++;
        step();
        total++; if (a_cnt !== W'(7))          $display("FAIL hold_cnt: got %0d want 7", a_cnt);            else passed++;
        a_stop = 1'b0; a_start = 1'b1;
        push_run(7, 1, 1'b0, 9);
        step();
        a_start = 1'b0;
        drain(1'b0, "resume7");
    endtask

    task automatic test_edge_cases();
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        total++; if (a_irq !== 1'b0) $display("FAIL ack_clear: got %b want 0", a_irq); else passed++;
        // Load 0 together with start: nothing to count, stays IDLE.
        if_a.load_val = '0; if_a.load_valid = 1'b1; a_start = 1'b1;
        step();
        if_a.load_valid = 1'b0; a_start = 1'b0;
        total++; if (a_running !== 1'b0) $display("FAIL zero_start_running: got %b want 1'b0", a_running); else passed++;
        total++; if (a_cnt !== '0)       $display("FAIL zero_start_cnt: got %0d want 0", a_cnt);          else passed++;
        // Acknowledge in the same cycle as the expiry: irq must still be set.
        if_a.load_val = W'(2); if_a.load_valid = 1'b1; a_start = 1'b1;
        step();
        if_a.load_valid = 1'b0; a_start = 1'b0;
        step();
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        total++; if (a_expire !== 1'b1) $display("FAIL ack_race_expire: got %b want 1", a_expire); else passed++;
        total++; if (a_irq !== 1'b1)    $display("FAIL ack_race_irq: got %b want 1", a_irq);       else passed++;
        step();
        total++; if (a_expire !== 1'b0) $display("FAIL expire_width: got %b want 0", a_expire);    else passed++;
        total++; if (a_irq !== 1'b1)    $display("FAIL irq_sticky: got %b want 1", a_irq);         else passed++;
    endtask

    task automatic test_reset_mid_run();
        if_a.load_val = W'(5); if_a.load_valid = 1'b1; a_start = 1'b1;
        step();
        if_a.load_valid = 1'b0; a_start = 1'b0;
        step();
        step();
        total++; if (a_cnt !== W'(3)) $display("FAIL midrun_cnt: got %0d want 3", a_cnt); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (a_cnt !== '0)       $display("FAIL midrun_reset_cnt: got %0d want 0", a_cnt);          else passed++;
        total++; if (a_running !== 1'b0) $display("FAIL midrun_reset_running: got %b want 0", a_running);   else passed++;
        step();
        reset = 1'b0;
        total++; if (a_expire !== 1'b0)  $display("FAIL midrun_reset_expire: got %b want 0", a_expire);     else passed++;
        total++; if (a_irq !== 1'b0)     $display("FAIL midrun_reset_irq: got %b want 0", a_irq);           else passed++;
        step();
        total++; if (a_expire !== 1'b0)  $display("FAIL post_reset_expire: got %b want 0", a_expire);       else passed++;
        // Load attempted while running must be refused.
        if_a.load_val = W'(9); if_a.load_valid = 1'b1; a_start = 1'b1;
        step();
        a_start = 1'b0; if_a.load_val = W'(100);
        #1;
        total++; if (if_a.load_ready !== 1'b0) $display("FAIL run_ready: got %b want 0", if_a.load_ready); else passed++;
        step();
        if_a.load_valid = 1'b0;
        total++; if (a_cnt !== W'(8)) $display("FAIL run_load_ignored: got %0d want 8", a_cnt); else passed++;
        a_stop = 1'b1;
        step();
        a_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_stop_resume();
        test_edge_cases();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
